// File: rtl/dispense_sequencer_if.sv
// ============================================================================
//  Module      : dispense_if
//  Description : Button/abort/dose request inputs and servo/status outputs of
//                the dispense sequencer, bundled for connection as one port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface dispense_if;
  logic        button;        // raw asynchronous button level, 1 = pressed
  logic [2:0]  doses;         // doses per request, 0 means 1
  logic        abort;         // synchronous level abort
  logic        servo_switch;  // servo position request, 1 = open
  logic        busy;          // sequencer not idle
  logic        done;          // one-cycle pulse at end of cooldown
  logic [15:0] dose_count;    // saturating count of doses started

  // Board side: drives the request inputs, observes servo and status
  modport master (
    output button, doses, abort,
    input  servo_switch, busy, done, dose_count
  );

  // Sequencer side
  modport slave (
    input  button, doses, abort,
    output servo_switch, busy, done, dose_count
  );
endinterface

`default_nettype wire

// File: rtl/dispense_sequencer.sv
// ============================================================================
//  Module      : dispense_sequencer
//  Description : Debounces the dispense button and runs the servo through a
//                timed open/settle cycle per dose followed by a cooldown
//                lockout. Feeds the switch input of servo_n_pos.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dispense_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int OPEN_CYCLES     = 25000000,
  parameter int SETTLE_CYCLES   = 25000000,
  parameter int COOLDOWN_CYCLES = 50000000,
  parameter int CNT_W           = 26
) (
  input  wire logic clk,
  input  wire logic rst_n,
  dispense_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_OPEN     = 2'd1,
    S_SETTLE   = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  // Terminal counts: a phase of N cycles ends when the timer shows N-1
  localparam logic [CNT_W-1:0] c_deb_last    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_open_last   = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cool_last   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

  state_t           r_state;
  state_t           w_next_state;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_deb;
  logic             r_deb_q;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_rem;
  logic             r_servo;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_dose_count;

  logic             w_start;
  logic             w_timer_last;
  logic             w_phase_change;

  // Two-flop synchronizer for the asynchronous button level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: accept a new level only after it has differed for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb     <= 1'b0;
      r_deb_q   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_deb_q <= r_deb;
      if (r_sync2 != r_deb) begin
        if (r_deb_cnt == c_deb_last) begin
          r_deb     <= r_sync2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + c_one;
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // A request is a rising edge of the debounced level; held buttons never retrigger
  assign w_start = r_deb & ~r_deb_q;

  // Next-state logic; abort outranks timer expiry in OPEN and SETTLE
  always_comb begin
    w_next_state = r_state;
    w_timer_last = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start && !bus.abort) begin
          w_next_state = S_OPEN;
        end
      end
      S_OPEN: begin
        w_timer_last = (r_timer == c_open_last);
        if (bus.abort) begin
          w_next_state = S_COOLDOWN;
        end else if (w_timer_last) begin
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_timer_last = (r_timer == c_settle_last);
        if (bus.abort) begin
          w_next_state = S_COOLDOWN;
        end else if (w_timer_last) begin
          w_next_state = (r_rem != 3'd0) ? S_OPEN : S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        w_timer_last = (r_timer == c_cool_last);
        if (w_timer_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_phase_change = (w_next_state != r_state);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Shared phase timer (restarts on every state change) and remaining-dose register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_rem   <= 3'd0;
    end else begin
      if (w_phase_change || (r_state == S_IDLE)) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + c_one;
      end

      if (w_next_state == S_COOLDOWN) begin
        r_rem <= 3'd0;
      end else if ((r_state == S_IDLE) && (w_next_state == S_OPEN)) begin
        r_rem <= (bus.doses == 3'd0) ? 3'd1 : bus.doses;
      end else if ((r_state == S_OPEN) && (w_next_state == S_SETTLE)) begin
        r_rem <= r_rem - 3'd1;
      end
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_servo      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dose_count <= 16'd0;
    end else begin
      r_servo <= (w_next_state == S_OPEN);
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (r_state == S_COOLDOWN) && (w_next_state == S_IDLE);
      if ((w_next_state == S_OPEN) && (r_state != S_OPEN) && (r_dose_count != 16'hFFFF)) begin
        r_dose_count <= r_dose_count + 16'd1;
      end
    end
  end

  assign bus.servo_switch = r_servo;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.dose_count   = r_dose_count;

endmodule

`default_nettype wire

// File: tb/tb_dispense_sequencer.sv
// ============================================================================
//  Module      : tb_dispense_sequencer
//  Description : Self-checking bench for dispense_sequencer. A schedule-based
//                reference model predicts servo/busy/done/dose_count for every
//                cycle from the time each request is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dispense_sequencer;

  localparam int D  = 4;
  localparam int O  = 10;
  localparam int S  = 6;
  localparam int C  = 8;
  localparam int P  = O + S;   // period of one dose
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  dispense_if u_bus ();

  dispense_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .OPEN_CYCLES     (O),
    .SETTLE_CYCLES   (S),
    .COOLDOWN_CYCLES (C),
    .CNT_W           (CW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  // A request accepted at cycle m_s with n doses opens the servo for the
  // first O cycles of every P-cycle period until m_end, then locks out for
  // C cycles; done marks the first idle cycle m_idle. Abort moves m_end.
  bit m_active;
  int m_s, m_n, m_end, m_idle;
  bit m_deb, m_rose;
  bit m_pipe[$];
  bit m_win[$];
  int m_count;

  function automatic void model_reset();
    m_active = 1'b0;
    m_deb    = 1'b0;
    m_rose   = 1'b0;
    m_pipe.delete();
    m_pipe.push_back(1'b0);
    m_pipe.push_back(1'b0);
    m_win.delete();
    m_count  = 0;
  endfunction

  function automatic void model_edge(int e, bit btn, bit [2:0] ds, bit ab);
    bit sample;
    bit all_diff;
    bit idle_pre;
    idle_pre = !m_active || ((e - 1) >= m_idle);
    if (m_rose && idle_pre && !ab) begin
      m_active = 1'b1;
      m_s      = e;
      m_n      = (ds == 3'd0) ? 1 : int'(ds);
      m_end    = m_s + m_n * P;
      m_idle   = m_end + C;
    end else if (m_active && ab && ((e - 1) >= m_s) && ((e - 1) < m_end)) begin
      m_end  = e;
      m_idle = e + C;
    end
    // two-sample delay, then accept a level seen D samples in a row
    sample = m_pipe.pop_front();
    m_pipe.push_back(btn);
    m_win.push_back(sample);
    if (m_win.size() > D) void'(m_win.pop_front());
    all_diff = (m_win.size() == D);
    foreach (m_win[i]) if (m_win[i] == m_deb) all_diff = 1'b0;
    m_rose = 1'b0;
    if (all_diff) begin
      m_deb  = !m_deb;
      m_rose = m_deb;
    end
    if (m_active && (e >= m_s) && (e < m_end) && (((e - m_s) % P) == 0) && (m_count < 65535))
      m_count++;
  endfunction

  function automatic bit exp_servo(int c);
    return m_active && (c >= m_s) && (c < m_end) && (((c - m_s) % P) < O);
  endfunction

  function automatic bit exp_busy(int c);
    return m_active && (c >= m_s) && (c < m_idle);
  endfunction

  function automatic bit exp_done(int c);
    return m_active && (c == m_idle);
  endfunction

  // ---------------------------------------------------------------- stepping
  int servo_hi;
  int done_seen;
  int first_hi;

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(cyc, u_bus.button, u_bus.doses, u_bus.abort);
    @(negedge clk);
    check("servo_switch", u_bus.servo_switch, exp_servo(cyc));
    check("busy", u_bus.busy, exp_busy(cyc));
    check("done", u_bus.done, exp_done(cyc));
    check("dose_count", u_bus.dose_count, m_count);
    if (u_bus.servo_switch === 1'b1) begin
      servo_hi++;
      if (first_hi < 0) first_hi = cyc;
    end
    if (u_bus.done === 1'b1) done_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (((u_bus.busy !== 1'b0) || exp_busy(cyc)) && (k < budget));
    check("wait_idle", u_bus.busy, 0);
  endtask

  task automatic wait_open(input int budget);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!exp_servo(cyc) && (k < budget));
    check("wait_open", u_bus.servo_switch, 1);
  endtask

  task automatic clear_stats();
    servo_hi  = 0;
    done_seen = 0;
    first_hi  = -1;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, "_servo"}, u_bus.servo_switch, 0);
    check({tag, "_busy"}, u_bus.busy, 0);
    check({tag, "_done"}, u_bus.done, 0);
    check({tag, "_count"}, u_bus.dose_count, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int k;
    int hold;
    u_bus.button = 1'b0;
    u_bus.doses  = 3'd1;
    u_bus.abort  = 1'b0;
    clear_stats();

    // power-on reset
    async_reset_check("reset");
    run(2);
    rst_n = 1'b1;
    run(3);

    // clean press, one dose: latency D+3 from button, 10 open cycles
    clear_stats();
    u_bus.doses  = 3'd1;
    u_bus.button = 1'b1;
    k = cyc;
    run(20);
    u_bus.button = 1'b0;
    wait_idle(200);
    check("t1_latency", first_hi - k, D + 3);
    check("t1_open_cycles", servo_hi, O);
    check("t1_done", done_seen, 1);
    check("t1_count", u_bus.dose_count, 1);
    run(3);

    // bouncing button: 2-cycle runs must not be accepted
    clear_stats();
    for (int i = 0; i < 6; i++) begin
      u_bus.button = (i % 2 == 0);
      run(2);
    end
    check("t2_quiet_bounce", servo_hi, 0);
    u_bus.button = 1'b1;
    wait_open(40);
    u_bus.button = 1'b0;
    wait_idle(200);
    check("t2_open_cycles", servo_hi, O);
    check("t2_done", done_seen, 1);
    check("t2_count", u_bus.dose_count, 2);
    run(3);

    // three doses, doses input changed to 0 mid-sequence
    clear_stats();
    u_bus.doses  = 3'd3;
    u_bus.button = 1'b1;
    wait_open(40);
    u_bus.button = 1'b0;
    u_bus.doses  = 3'd0;
    wait_idle(200);
    check("t3_open_cycles", servo_hi, 3 * O);
    check("t3_done", done_seen, 1);
    check("t3_count", u_bus.dose_count, 5);
    run(3);

    // doses = 0 behaves as one dose
    clear_stats();
    u_bus.doses  = 3'd0;
    u_bus.button = 1'b1;
    wait_open(40);
    u_bus.button = 1'b0;
    wait_idle(200);
    check("t4_open_cycles", servo_hi, O);
    check("t4_count", u_bus.dose_count, 6);
    run(3);

    // abort in the 5th open cycle of dose 1 of 2
    clear_stats();
    u_bus.doses  = 3'd2;
    u_bus.button = 1'b1;
    wait_open(40);
    u_bus.button = 1'b0;
    run(4);
    u_bus.abort = 1'b1;
    step();
    u_bus.abort = 1'b0;
    check("t5_servo_after_abort", u_bus.servo_switch, 0);
    check("t5_busy_after_abort", u_bus.busy, 1);
    wait_idle(200);
    check("t5_open_cycles", servo_hi, 5);
    check("t5_done", done_seen, 1);
    check("t5_count", u_bus.dose_count, 7);
    run(3);

    // second press during cooldown is discarded; held button does not retrigger
    clear_stats();
    u_bus.doses  = 3'd1;
    u_bus.button = 1'b1;
    wait_open(40);
    u_bus.button = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while ((cyc < m_end) && (k < 100));
    check("t6_in_cooldown", u_bus.busy, 1);
    u_bus.button = 1'b1;
    run(10);
    wait_idle(200);
    run(5);
    u_bus.button = 1'b0;
    run(8);
    check("t6_done", done_seen, 1);
    check("t6_count", u_bus.dose_count, 8);

    // reset while open
    u_bus.doses  = 3'd2;
    u_bus.button = 1'b1;
    wait_open(40);
    run(2);
    async_reset_check("t7_midreset");
    u_bus.button = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(3);

    // randomized traffic
    for (int it = 0; it < 150; it++) begin
      hold         = $urandom_range(1, 12);
      u_bus.button = 1'($urandom_range(0, 1));
      u_bus.doses  = 3'($urandom_range(0, 7));
      u_bus.abort  = ($urandom_range(0, 7) == 0);
      for (int j = 0; j < hold; j++) begin
        step();
        u_bus.abort = 1'b0;
      end
    end
    u_bus.button = 1'b0;
    wait_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
- Sequences the dispenser servo.
- Debounces the physical button and accepts one dispense request at a time.
- Drives the servo position request (1 = open, 0 = closed) through a timed open/settle/cooldown cycle, repeated for a configurable number of doses.
- Sits between the board button input and the `switch` input of `servo_n_pos`, replacing the direct button-to-servo wiring in the dispenser top level.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz).
- OPEN_CYCLES, 25000000, cycles the servo is held open per dose.
- SETTLE_CYCLES, 25000000, cycles the servo is held closed between doses and after the last dose.
- COOLDOWN_CYCLES, 50000000, lockout cycles after a sequence before a new request is accepted.
- CNT_W, 26, width of the shared phase timer; must hold max(DEBOUNCE_CYCLES, OPEN_CYCLES, SETTLE_CYCLES, COOLDOWN_CYCLES).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- button  input  1  raw, asynchronous button level; 1 = pressed.
- doses  input  3  doses per request, sampled at request acceptance; 0 is treated as 1.
- abort  input  1  synchronous abort; level-sensitive, sampled every cycle.
- servo_switch  output  1  position request to `servo_n_pos`; 1 = open.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse on COOLDOWN->IDLE.
- dose_count  output  16  total doses started since reset, saturating.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, servo_switch=0, busy=0, done=0, dose_count=0.
  - Synchronizer flops=0, debounced level=0, timers=0, remaining-dose register=0.
- Input path:
  - button passes through a 2-flop synchronizer.
  - Debounce counter counts while the synchronized value differs from the debounced level and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level updates on that edge and the counter clears.
  - start = rising edge of the debounced level (one-cycle pulse).
- FSM states: IDLE, OPEN, SETTLE, COOLDOWN. All outputs are registered.
- IDLE:
  - On start with abort=0: latch rem = (doses==0 ? 1 : doses), go to OPEN, clear the timer.
  - start with abort=1 is ignored.
- OPEN:
  - servo_switch=1.
  - dose_count increments (saturating at 0xFFFF) in the cycle OPEN is entered.
  - After OPEN_CYCLES cycles in OPEN: rem <= rem-1, go to SETTLE.
- SETTLE:
  - servo_switch=0.
  - After SETTLE_CYCLES cycles: if rem != 0 go to OPEN, else go to COOLDOWN.
- COOLDOWN:
  - servo_switch=0.
  - After COOLDOWN_CYCLES cycles go to IDLE and pulse done for one cycle.
- Output timing:
  - servo_switch rises in the first cycle state==OPEN: 1 cycle after the start pulse, 3 + DEBOUNCE_CYCLES cycles after a clean button rise.
  - Open width is exactly OPEN_CYCLES cycles per dose.
- Abort:
  - abort=1 in OPEN or SETTLE: next cycle state=COOLDOWN, servo_switch=0, rem=0, timer cleared. No dose_count change.
  - abort in COOLDOWN or IDLE: no effect.
- Requests while busy:
  - start pulses while busy=1 are discarded, not queued.
  - A button held through COOLDOWN does not re-trigger; a new rising edge of the debounced level is required.
- Simultaneous events:
  - abort has priority over timer expiry in the same cycle.
  - done and an accepted start cannot coincide, because start is evaluated only when state==IDLE.
- Width rules:
  - The phase timer is a single CNT_W counter, cleared on every state change.
  - rem is 3 bits.
  - dose_count does not wrap.
- Reset mid-operation: immediate return to reset values; servo_switch=0 asynchronously.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, OPEN_CYCLES=10, SETTLE_CYCLES=6, COOLDOWN_CYCLES=8):
- Clean press, doses=1: button 0->1 held 20 cycles.
  - servo_switch high exactly 10 cycles, starting 1 cycle after the start pulse.
  - Then 6 closed settle cycles and 8 cooldown cycles.
  - done pulses once; dose_count=1; busy returns to 0.
- Bounce: button toggles every 2 cycles for 12 cycles, then held high.
  - Exactly one start.
  - No servo_switch activity until the level is stable 4 cycles.
- doses=3, then doses changed to 0 mid-sequence: three 10-cycle open pulses separated by 6-cycle closed gaps; dose_count=3; done once.
- doses=0: behaves as 1 dose; dose_count=1.
- Abort in the 5th cycle of OPEN of dose 1 of 2.
  - Next cycle servo_switch=0, state COOLDOWN.
  - After 8 cycles, done pulses; dose_count=1.
- Second press during COOLDOWN, and rst_n pulsed low during OPEN.
  - The press is ignored (dose_count unchanged).
  - On reset, servo_switch drops immediately, with all outputs at reset values.
